// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: controller states and default operand width.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; the only arithmetic element in the serial datapath.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic sum,
   output logic c_out
);

   assign sum   = a ^ b ^ c_in;
   assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: LSB-first, one full-adder step per cycle, WIDTH+1 cycles per add back-to-back.
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_sr, b_sr;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             accept, last;
   logic             fa_sum, fa_cout;

   full_adder u_fa (
      .a     (a_sr[0]),
      .b     (b_sr[0]),
      .c_in  (carry),
      .sum   (fa_sum),
      .c_out (fa_cout)
   );

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      last     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            if (cnt == LAST) begin
               last     = 1'b1;
               state_nx = DONE;
            end
         end
         DONE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = RUN;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Sum bits enter at the MSB so that after WIDTH shifts bit 0 lands at position 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr  <= '0;
         b_sr  <= '0;
         cnt   <= '0;
         carry <= 1'b0;
         sum   <= '0;
         c_out <= 1'b0;
      end else if (accept) begin
         a_sr  <= a;
         b_sr  <= b;
         cnt   <= '0;
         carry <= c_in;
         sum   <= '0;
         c_out <= 1'b0;
      end else if (state == RUN) begin
         a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
         b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
         sum   <= {fa_sum, sum[WIDTH-1:1]};
         carry <= fa_cout;
         cnt   <= cnt + 1'b1;
         if (last) begin
            c_out <= fa_cout;
         end
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8: vector table, corner sequences, random regression.
module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a, b;
   logic         c_in;
   logic         busy, done;
   logic [W-1:0] sum;
   logic         c_out;

   int errors = 0;
   int checks = 0;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .c_in  (c_in),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .c_out (c_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         ci;
      logic [W-1:0] exp_sum;
      logic         exp_co;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one add; returns result, cycles from accept to done, and busy cycles seen.
   // With noise set, operands and start are scrambled while the add is in flight.
   task automatic run_add(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                          input bit noise, output logic [W-1:0] s, output logic co,
                          output int lat, output int busy_cnt);
      @(negedge clk);
      a = av; b = bv; c_in = ci; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      busy_cnt = 0;
      while (!done && lat < 30) begin
         if (busy) busy_cnt++;
         if (noise) begin
            a = W'($urandom); b = W'($urandom); c_in = 1'($urandom); start = 1'($urandom);
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      if (!done) chk("done_timeout", 32'(lat), 32'd9);
      s  = sum;
      co = c_out;
   endtask

   initial begin
      logic [W-1:0] s;
      logic         co;
      logic [W:0]   ref_v;
      int           lat, bc, pulses;

      vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
      vecs[3] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
      vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
      vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

      rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
      #12;
      chk("reset_busy", 32'(busy), 0);
      chk("reset_done", 32'(done), 0);
      chk("reset_sum", 32'(sum), 0);
      chk("reset_cout", 32'(c_out), 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         run_add(vecs[i].a, vecs[i].b, vecs[i].ci, 1'b0, s, co, lat, bc);
         chk($sformatf("vec%0d_sum", i), 32'(s), 32'(vecs[i].exp_sum));
         chk($sformatf("vec%0d_cout", i), 32'(co), 32'(vecs[i].exp_co));
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd9);
         chk($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'd8);
         chk($sformatf("vec%0d_busy_in_done", i), 32'(busy), 0);
         @(negedge clk);
         chk($sformatf("vec%0d_done_pulse_len", i), 32'(done), 0);
         chk($sformatf("vec%0d_hold_sum", i), 32'(sum), 32'(vecs[i].exp_sum));
         chk($sformatf("vec%0d_hold_cout", i), 32'(c_out), 32'(vecs[i].exp_co));
      end

      // Operand change and start pulse during RUN must not disturb the add.
      @(negedge clk);
      a = 8'h3C; b = 8'h0F; c_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      pulses = 0;
      for (int i = 0; i < 16; i++) begin
         if (i == 2) begin a = 8'hFF; start = 1'b1; end
         if (i == 3) start = 1'b0;
         if (done) begin
            pulses++;
            chk("ignore_start_sum", 32'(sum), 32'h4B);
            chk("ignore_start_cout", 32'(c_out), 0);
         end
         @(negedge clk);
      end
      chk("ignore_start_pulses", 32'(pulses), 1);

      // Asynchronous reset in the 4th RUN cycle, with partial sum bits already set.
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         a = (k == 0) ? 8'h80 : 8'hFF; b = a; c_in = 1'b0; start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         repeat (3) @(negedge clk);
         chk($sformatf("rst%0d_busy_before", k), 32'(busy), 1);
         #2 rst = 1'b1;
         #1;
         chk($sformatf("rst%0d_busy", k), 32'(busy), 0);
         chk($sformatf("rst%0d_done", k), 32'(done), 0);
         chk($sformatf("rst%0d_sum", k), 32'(sum), 0);
         chk($sformatf("rst%0d_cout", k), 32'(c_out), 0);
         @(negedge clk);
         rst = 1'b0;
         run_add(8'h12, 8'h34, 1'b1, 1'b0, s, co, lat, bc);
         chk($sformatf("rst%0d_after_sum", k), 32'(s), 32'h47);
         chk($sformatf("rst%0d_after_latency", k), 32'(lat), 32'd9);
      end

      // Back-to-back: start held through DONE.
      run_add(8'h10, 8'h20, 1'b0, 1'b0, s, co, lat, bc);
      chk("b2b_first_sum", 32'(s), 32'h30);
      a = 8'h01; b = 8'h02; c_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (!done && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      chk("b2b_spacing", 32'(lat), 32'd9);
      chk("b2b_sum", 32'(sum), 32'h03);
      chk("b2b_cout", 32'(c_out), 0);

      // Random regression against plain integer addition, with in-flight input noise.
      for (int i = 0; i < 1000; i++) begin
         logic [W-1:0] ra, rb;
         logic         rc;
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
         ref_v = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
         run_add(ra, rb, rc, 1'b1, s, co, lat, bc);
         chk($sformatf("rand%0d_result", i), 32'({co, s}), 32'(ref_v));
         if (lat != 9) chk($sformatf("rand%0d_latency", i), 32'(lat), 32'd9);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  request to add a, b and c_in; sampled on clk rising edge.
REQ-006 a  input  WIDTH  operand A; sampled only when start is accepted.
REQ-007 b  input  WIDTH  operand B; sampled only when start is accepted.
REQ-008 c_in  input  1  carry-in; sampled only when start is accepted.
REQ-009 busy  output  1  high while bits are being processed.
REQ-010 done  output  1  one-cycle pulse when sum and c_out become valid.
REQ-011 sum  output  WIDTH  registered result, a+b+c_in mod 2^WIDTH.
REQ-012 c_out  output  1  registered carry-out of the full WIDTH-bit addition.

Function
REQ-013 The block SHALL compute the sum bit-serially, LSB first, using exactly one 1-bit full adder per cycle.
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 In IDLE or DONE, start=1 SHALL be accepted: load operand shift registers from a and b, load carry from c_in, clear the bit counter, clear sum, and go to RUN.
REQ-016 In RUN, each edge SHALL add the operand LSBs and the carry register, shift the sum bit into sum from the MSB end, shift both operands right, store the full-adder carry-out and increment the counter.
REQ-017 The counter SHALL advance from 0 through WIDTH-1; the edge that processes bit WIDTH-1 SHALL move RUN to DONE and load c_out.
REQ-018 start SHALL be ignored while in RUN; a, b and c_in changes during RUN SHALL NOT affect the result.
REQ-019 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-020 Latency: if start is accepted at edge 0, done SHALL be high in the cycle after edge WIDTH, for one cycle.
REQ-021 DONE SHALL go to IDLE after one cycle unless start=1, which SHALL go directly to RUN (back-to-back operation, WIDTH+1 cycles per add).
REQ-022 sum and c_out SHALL hold their final values in DONE and IDLE until the next accepted start clears them.
REQ-023 Carry SHALL ripple through the carry register only; no combinational path SHALL exist from a, b or c_in to any output.

Reset
REQ-024 rst=1 SHALL, asynchronously and at any time including mid-RUN, force state to IDLE and set busy=0, done=0, sum=0, c_out=0, counter=0, carry=0.
REQ-025 The first start SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-026 A shared package serial_adder_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-027 The 1-bit adder SHALL be a separate sub-module full_adder (ports a, b, c_in, sum, c_out), instantiated once.
REQ-028 The counter SHALL be $clog2(WIDTH) bits wide.

Verification (WIDTH=8)
REQ-029 a=0x00, b=0x00, c_in=0, start for 1 cycle -> busy for 8 cycles, done pulse on the 9th cycle, sum=0x00, c_out=0.
REQ-030 a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1; a=0xA5, b=0x5A, c_in=1 -> sum=0x00, c_out=1.
REQ-031 a=0x3C, b=0x0F, c_in=0; change a to 0xFF and pulse start during RUN -> result unaffected: sum=0x4B, c_out=0, single done pulse.
REQ-032 Start 0x80+0x80; assert rst at the 4th RUN cycle -> outputs go to 0 and state to IDLE immediately; a new start after release gives a correct result.
REQ-033 Hold start high through DONE with new operands 0x01+0x02 -> second done pulse exactly 9 cycles after the first, sum=0x03.
REQ-034 Random regression: 1000 random a, b, c_in -> {c_out,sum} SHALL equal a+b+c_in every time.
